// File: rtl/bus_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_access_arbiter_pkg
// Description : Shared types and requester indices for the memory-port
//               arbiter and other shared-resource arbiters.
//               Contents:
//                 ArbiterState    - Idle/Busy state encoding
//                 REQ_*           - fixed requester slot assignments
//                 idx_width()     - index width helper for N-way pickers
// Revision    : 1.0 - initial release
// ============================================================================
package bus_access_arbiter_pkg;

    typedef enum logic [0:0] {
        State_Idle = 1'b0,
        State_Busy = 1'b1
    } ArbiterState;

    localparam int REQ_ITLB   = 0;
    localparam int REQ_ICACHE = 1;
    localparam int REQ_DTLB   = 2;
    localparam int REQ_DCACHE = 3;

    // Width of an index into N items; never below one bit so a single-way
    // arbiter still has a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_access_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_picker
// Description : Combinational round-robin selector. Scans the eligible
//               requests starting one slot after rr_ptr_i, wrapping modulo N,
//               and reports the first hit.
//               Ports:
//                 req_i     [N]     raw request vector
//                 rr_ptr_i  [IDX_W] index of the most recently served slot
//                 mask_i    [N]     eligibility mask (all ones = unrestricted)
//                 valid_o           at least one eligible request
//                 winner_o  [IDX_W] index of the selected request
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_picker
    import bus_access_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    input  logic [N-1:0]     mask_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] winner_o
);

    logic [N-1:0] elig_w;

    always_comb begin
        int          pos;
        logic [IDX_W-1:0] idx;
        elig_w   = req_i & mask_i;
        valid_o  = 1'b0;
        winner_o = '0;
        // Offset 1 first, so the slot just served is considered last.
        for (int k = 1; k <= N; k++) begin
            pos = int'(rr_ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IDX_W'(pos);
            if (elig_w[idx] && !valid_o) begin
                valid_o  = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_access_arbiter
// Description : Shares one memory port between the ITLB walker, ICache
//               replacer, DTLB walker and DCache replacer. One transaction
//               at a time, round-robin priority, with an optional lock that
//               keeps ownership across back-to-back transactions (PTE read
//               followed by A/D-bit write).
//               Ports:
//                 clk, rst (async, active-low)
//                 req/lock/write [N_REQ]     per-requester controls
//                 addr  [N_REQ*ADDR_WIDTH]   packed request addresses
//                 wdata [N_REQ*DATA_WIDTH]   packed write data
//                 done  [N_REQ]              one-hot completion pulse
//                 rdata [DATA_WIDTH]         read data, valid with done
//                 mem_req/mem_write/mem_addr/mem_wdata  memory request side
//                 mem_done/mem_rdata                    memory response side
// Revision    : 1.0 - initial release
// ============================================================================
module bus_access_arbiter
    import bus_access_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            lock,
    input  logic [N_REQ-1:0]            write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        mem_req,
    output logic                        mem_write,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic                        mem_done,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);

    localparam int IDX_W = idx_width(N_REQ);

    ArbiterState            state_q,     state_d;
    logic [IDX_W-1:0]       owner_q,     owner_d;
    logic [IDX_W-1:0]       rr_ptr_q,    rr_ptr_d;
    logic                   locked_q,    locked_d;
    logic                   mem_req_q,   mem_req_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q,     rdata_d;

    logic [ADDR_WIDTH-1:0]  addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [N_REQ];
    logic [N_REQ-1:0]       owner_oh;
    logic [N_REQ-1:0]       pick_mask;
    logic                   lock_hold;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;
    logic                   completing;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        owner_oh           = '0;
        owner_oh[owner_q]  = 1'b1;
    end

    // The lock only restricts arbitration while its owner keeps requesting;
    // once the owner lets go, everyone competes again in the same cycle.
    assign lock_hold = locked_q && req[owner_q];
    assign pick_mask = lock_hold ? owner_oh : {N_REQ{1'b1}};

    round_robin_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .mask_i   (pick_mask),
        .valid_o  (pick_valid),
        .winner_o (pick_idx)
    );

    // Completion is reported in the same cycle as mem_done; a mem_done seen
    // while Idle has no owner and is dropped.
    assign completing = (state_q == State_Busy) && mem_done;
    assign done       = completing ? owner_oh : '0;
    assign rdata      = completing ? mem_rdata : rdata_q;

    assign mem_req    = mem_req_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        locked_d    = locked_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        case (state_q)
            State_Idle: begin
                locked_d = lock_hold;
                if (pick_valid) begin
                    state_d     = State_Busy;
                    owner_d     = pick_idx;
                    rr_ptr_d    = pick_idx;
                    mem_req_d   = 1'b1;
                    mem_write_d = write[pick_idx];
                    mem_addr_d  = addr_arr[pick_idx];
                    mem_wdata_d = wdata_arr[pick_idx];
                end
            end
            State_Busy: begin
                if (mem_done) begin
                    state_d   = State_Idle;
                    mem_req_d = 1'b0;
                    locked_d  = lock[owner_q];
                    rdata_d   = mem_rdata;
                end
            end
            default: begin
                state_d   = State_Idle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= State_Idle;
            owner_q     <= '0;
            rr_ptr_q    <= IDX_W'(N_REQ - 1);
            locked_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            locked_q    <= locked_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_access_arbiter
// Description : Self-checking bench for bus_access_arbiter. A transaction-
//               level model (last-served index, lock owner, in-flight
//               request) predicts every output each cycle; directed tasks add
//               ordering and latency checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_access_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int AW = 30;
    localparam int DW = 128;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    d_req, d_lock, d_write;
    logic [AW-1:0]   d_addr  [N];
    logic [DW-1:0]   d_wdata [N];
    logic            d_mem_done;
    logic [DW-1:0]   d_mem_rdata;
    logic [N*AW-1:0] addr_bus;
    logic [N*DW-1:0] wdata_bus;

    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            mem_req, mem_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;

    always #5 clk = ~clk;

    always_comb begin
        addr_bus  = '0;
        wdata_bus = '0;
        for (int i = 0; i < N; i++) begin
            addr_bus[i*AW +: AW]  = d_addr[i];
            wdata_bus[i*DW +: DW] = d_wdata[i];
        end
    end

    bus_access_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (d_req),
        .lock      (d_lock),
        .write     (d_write),
        .addr      (addr_bus),
        .wdata     (wdata_bus),
        .done      (done),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (d_mem_done),
        .mem_rdata (d_mem_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level reference model
    logic          m_busy;
    logic          m_locked;
    int            m_owner;
    int            m_last;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    // Observations of the most recent cycle, for directed checks
    logic [N-1:0]  obs_done;
    logic          obs_mem_req;
    logic          obs_mem_write;
    logic [AW-1:0] obs_mem_addr;
    logic [DW-1:0] obs_rdata;
    int            last_done_idx;
    int            done_log[$];

    function automatic void model_reset();
        m_busy   = 1'b0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_write  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_rdata  = '0;
    endfunction

    // Next winner from the requests visible in an Idle cycle, or -1.
    function automatic int model_pick(input logic [N-1:0] r);
        int j;
        if (m_locked && r[IW'(m_owner)]) return m_owner;
        for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (r[IW'(j)]) return j;
        end
        return -1;
    endfunction

    // One clock cycle: check outputs against the model, advance the model,
    // and apply the requester rule that req drops after its done pulse.
    task automatic step();
        logic [N-1:0] exp_done;
        int           w;
        int           clr;
        clr           = -1;
        last_done_idx = -1;
        #3;
        obs_done      = done;
        obs_mem_req   = mem_req;
        obs_mem_write = mem_write;
        obs_mem_addr  = mem_addr;
        obs_rdata     = rdata;

        n_cmp++;
        if (mem_req !== m_busy) begin
            n_fail++;
            $display("FAIL mem_req t=%0t got %b exp %b", $time, mem_req, m_busy);
        end
        if (m_busy) begin
            n_cmp++;
            if (mem_addr !== m_addr || mem_write !== m_write || mem_wdata !== m_wdata) begin
                n_fail++;
                $display("FAIL mem_cmd t=%0t got a=%h w=%b d=%h exp a=%h w=%b d=%h",
                         $time, mem_addr, mem_write, mem_wdata, m_addr, m_write, m_wdata);
            end
        end
        exp_done = (m_busy && d_mem_done) ? (N'(1) << m_owner) : '0;
        n_cmp++;
        if (done !== exp_done) begin
            n_fail++;
            $display("FAIL done t=%0t got %b exp %b", $time, done, exp_done);
        end
        if (exp_done != '0) m_rdata = d_mem_rdata;
        n_cmp++;
        if (rdata !== m_rdata) begin
            n_fail++;
            $display("FAIL rdata t=%0t got %h exp %h", $time, rdata, m_rdata);
        end

        if (m_busy) begin
            if (d_mem_done) begin
                m_busy   = 1'b0;
                m_locked = d_lock[IW'(m_owner)];
                clr      = m_owner;
                last_done_idx = m_owner;
                done_log.push_back(m_owner);
            end
        end else begin
            if (m_locked && !d_req[IW'(m_owner)]) m_locked = 1'b0;
            w = model_pick(d_req);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_last  = w;
                m_write = d_write[IW'(w)];
                m_addr  = d_addr[w];
                m_wdata = d_wdata[w];
            end
        end

        @(posedge clk);
        #1;
        if (clr >= 0) d_req[IW'(clr)] = 1'b0;
    endtask

    task automatic clear_inputs();
        d_req       = '0;
        d_lock      = '0;
        d_write     = '0;
        d_mem_done  = 1'b0;
        d_mem_rdata = '0;
        for (int i = 0; i < N; i++) begin
            d_addr[i]  = '0;
            d_wdata[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((m_busy || d_req != '0) && t < 100) begin
            d_mem_done  = m_busy && ($urandom_range(0, 1) == 0);
            d_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            t++;
        end
        d_mem_done = 1'b0;
        n_cmp++;
        if (m_busy || d_req != '0) begin
            n_fail++;
            $display("FAIL drain_timeout got busy=%b req=%b exp idle", m_busy, d_req);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst         = 1'b0;
        d_req       = '1;
        d_mem_done  = 1'b1;
        d_mem_rdata = '1;
        @(posedge clk);
        #2;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_ctl got req=%b wr=%b exp 0 0", mem_req, mem_write);
        end
        n_cmp++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_data got a=%h d=%h exp 0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if (done !== '0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_resp got done=%b rdata=%h exp 0", done, rdata);
        end
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        int t, memreq_at, done_at;
        t = 0; memreq_at = -1; done_at = -1;
        d_addr[1]  = 30'h100;
        d_write[1] = 1'b0;
        d_req[1]   = 1'b1;
        while (t < 20 && done_at < 0) begin
            d_mem_done  = (memreq_at >= 0) && (t == memreq_at + 3);
            d_mem_rdata = 128'hDEAD_BEEF;
            step();
            if (obs_mem_req && memreq_at < 0) begin
                memreq_at = t;
                n_cmp++;
                if (obs_mem_addr !== 30'h100 || obs_mem_write !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_cmd got a=%h w=%b exp a=100 w=0", obs_mem_addr, obs_mem_write);
                end
            end
            if (obs_done != '0) begin
                done_at = t;
                n_cmp++;
                if (obs_done !== 4'b0010 || obs_rdata !== 128'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL single_resp got done=%b rdata=%h exp 0010 deadbeef", obs_done, obs_rdata);
                end
            end
            t++;
        end
        d_mem_done = 1'b0;
        n_cmp++;
        if (memreq_at != 1 || done_at != 4) begin
            n_fail++;
            $display("FAIL single_latency got memreq@%0d done@%0d exp 1 4", memreq_at, done_at);
        end
    endtask

    task automatic test_round_robin();
        int t;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) d_addr[i] = AW'(32'h40 * (i + 1));
        done_log.delete();
        d_req = '1;
        t = 0;
        while (done_log.size() < 5 && t < 60) begin
            d_mem_done  = m_busy && ($urandom_range(0, 1) == 0);
            d_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            d_req = '1;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= done_log.size() || done_log[i] != exp_order[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got %0d exp %0d", i,
                         (i < done_log.size()) ? done_log[i] : -1, exp_order[i]);
            end
        end
        d_req = '0;
        drain();
    endtask

    task automatic test_lock_rmw();
        int t, phase;
        int exp_order [3] = '{0, 0, 3};
        do_reset();
        done_log.delete();
        d_addr[0] = 30'h200; d_write[0] = 1'b0; d_lock[0] = 1'b1;
        d_addr[3] = 30'h3C0; d_write[3] = 1'b0;
        d_req     = 4'b1001;
        t = 0; phase = 0;
        while (done_log.size() < 3 && t < 60) begin
            d_mem_done  = m_busy && ($urandom_range(0, 2) == 0);
            d_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (phase == 0 && last_done_idx == 0) begin
                // Owner keeps req high and issues the A/D-bit write.
                d_req[0]   = 1'b1;
                d_write[0] = 1'b1;
                d_lock[0]  = 1'b0;
                d_wdata[0] = 128'h0000_00C0;
                phase      = 1;
            end
            t++;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= done_log.size() || done_log[i] != exp_order[i]) begin
                n_fail++;
                $display("FAIL lock_order[%0d] got %0d exp %0d", i,
                         (i < done_log.size()) ? done_log[i] : -1, exp_order[i]);
            end
        end
        drain();
    endtask

    task automatic test_drop_req();
        int t, busy_at, done_at, next_at;
        t = 0; busy_at = -1; done_at = -1; next_at = -1;
        d_addr[2] = 30'h2A0;
        d_write[2] = 1'b0;
        d_req[2]  = 1'b1;
        while (t < 30 && next_at < 0) begin
            d_mem_done  = (busy_at >= 0) && (t == busy_at + 3) && (done_at < 0);
            d_mem_rdata = 128'h1234;
            step();
            if (obs_mem_req && busy_at < 0) begin
                busy_at  = t;
                d_req[2] = 1'b0;
                d_req[1] = 1'b1;
                d_addr[1] = 30'h111;
            end
            if (obs_done != '0 && done_at < 0) begin
                done_at = t;
                n_cmp++;
                if (obs_done !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL drop_done got %b exp 0100", obs_done);
                end
            end else if (done_at >= 0 && obs_mem_req && next_at < 0) begin
                next_at = t;
            end
            t++;
        end
        n_cmp++;
        if (done_at < 0 || next_at != done_at + 2) begin
            n_fail++;
            $display("FAIL drop_regrant got done@%0d next_mem_req@%0d exp gap 2", done_at, next_at);
        end
        drain();
    endtask

    task automatic test_async_reset();
        int t;
        d_req = 4'b1000;
        d_addr[3] = 30'h3FF;
        t = 0;
        while (!m_busy && t < 10) begin
            step();
            t++;
        end
        // Now one cycle into Busy; pull reset between edges.
        d_mem_done = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || done !== '0) begin
            n_fail++;
            $display("FAIL async_rst got mem_req=%b done=%b exp 0 0000", mem_req, done);
        end
        model_reset();
        d_mem_done = 1'b0;
        d_req      = '1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        done_log.delete();
        t = 0;
        while (done_log.size() < 1 && t < 20) begin
            d_mem_done  = m_busy;
            d_mem_rdata = 128'h5;
            step();
            d_req = '1;
            t++;
        end
        n_cmp++;
        if (done_log.size() < 1 || done_log[0] != 0) begin
            n_fail++;
            $display("FAIL async_rst_first got %0d exp 0", (done_log.size() > 0) ? done_log[0] : -1);
        end
        d_req = '0;
        drain();
    endtask

    task automatic test_spurious_done();
        drain();
        d_req = '0;
        for (int i = 0; i < 4; i++) begin
            d_mem_done  = 1'b1;
            d_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            n_cmp++;
            if (obs_done !== '0 || obs_mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious got done=%b mem_req=%b exp 0000 0", obs_done, obs_mem_req);
            end
        end
        d_mem_done = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!d_req[IW'(i)] && $urandom_range(0, 3) == 0) begin
                    d_req[IW'(i)]   = 1'b1;
                    d_write[IW'(i)] = 1'($urandom_range(0, 1));
                    d_lock[IW'(i)]  = ($urandom_range(0, 2) == 0);
                    d_addr[i]       = AW'($urandom);
                    d_wdata[i]      = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            // Occasionally the owner abandons its request mid-transaction.
            if (m_busy && $urandom_range(0, 15) == 0) d_req[IW'(m_owner)] = 1'b0;
            d_mem_done  = ($urandom_range(0, 3) == 0);
            d_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            // A locked owner sometimes continues straight into a follow-up.
            if (last_done_idx >= 0 && d_lock[IW'(last_done_idx)] && $urandom_range(0, 1) == 0) begin
                d_req[IW'(last_done_idx)]   = 1'b1;
                d_write[IW'(last_done_idx)] = 1'b1;
                d_lock[IW'(last_done_idx)]  = 1'b0;
                d_addr[last_done_idx]       = AW'($urandom);
            end
        end
        drain();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_rmw();
        test_drop_req();
        test_async_reset();
        test_spurious_done();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
